state_frame_tx: RTL and testbench
=================================

Name: state_frame_tx

Overview:
Parametrised SPI frame transmitter for game-state exchange between the two boards. It captures NUM_CH independently-valid data channels (player FSM state, location, score, ...) into shadow registers. Once every channel in a runtime-selectable required mask has been refreshed, it serialises one framed packet: header, sequence number, channels and XOR checksum. Start-handshake gating lets the opponent see when this board is present.

Parameters:
NUM_CH, 2, number of input channels (1..8)
CH_WIDTH, 48, width of each channel in bits
SEQ_WIDTH, 4, sequence-number width
DATA_PERIOD, 100, clk cycles per serial bit (even, >=2)
HEADER, 8'hA5, 8-bit frame start byte
INIT_RECV, '0, NUM_CH-bit reset value of the received flags

Ports:
clk_pixel_in  in  1  system clock
rst_n_in  in  1  synchronous reset, active-low
self_started_in  in  1  local player has started
opponent_started_in  in  1  opponent has started
ch_data_in  in  NUM_CH*CH_WIDTH  channel i at bits [i*CH_WIDTH +: CH_WIDTH]
ch_valid_in  in  NUM_CH  per-channel load strobe
ch_required_in  in  NUM_CH  channels that must be fresh before a send
data_out  out  1  serial data, MSB first
data_clk_out  out  1  serial clock
sel_out  out  1  frame select, active-low
busy_out  out  1  frame in progress (LOAD/SHIFT/GAP)
frame_sent_out  out  1  one-cycle pulse at end of GAP
seq_out  out  SEQ_WIDTH  sequence number of the next frame

Behaviour:
- Reset (rst_n_in=0 at posedge) values: data_out=0, data_clk_out=0, sel_out=1, busy_out=0, frame_sent_out=0, seq_out=0, recv=INIT_RECV, shadows=0, state IDLE. Reset applied mid-frame aborts it immediately; no partial completion.
- Frame layout: FRAME_W = 8+SEQ_WIDTH+NUM_CH*CH_WIDTH+8. Fields, MSB first: {HEADER, seq, ch[NUM_CH-1]..ch[0], csum}.
- Checksum: payload P={seq, channels}, zero-extended at the MSB to a multiple of 8 bits. csum = XOR of all bytes of P.
- Capture: ch_valid_in[i]=1 latches channel i into its shadow and sets recv[i]. This is accepted in every state, including while shifting; the frame in flight uses the snapshot taken at LOAD.
- Trigger condition: state IDLE, self_started_in=1, opponent_started_in=1, ch_required_in!=0, and (recv & ch_required_in)==ch_required_in.
- FSM:
  - IDLE: on trigger, go to LOAD.
  - LOAD: 1 cycle. Snapshot shadows+seq into the shift register with csum. Clear recv, except bits whose ch_valid_in is high this cycle (a new strobe wins over the clear).
  - SHIFT: FRAME_W bits. Each bit lasts DATA_PERIOD cycles. data_out changes at bit start. data_clk_out is low for the first DATA_PERIOD/2 cycles, high for the second half (sample on rising edge). sel_out=0 throughout SHIFT.
  - GAP: sel_out=1, data_clk_out=0 for DATA_PERIOD cycles. On the final GAP cycle, pulse frame_sent_out, increment seq mod 2^SEQ_WIDTH, and return to IDLE.
- Latency: trigger true at cycle t gives LOAD at t+1, sel_out=0 and first bit at t+2. sel_out returns to 1 at t+2+FRAME_W*DATA_PERIOD. frame_sent_out pulses at t+1+(FRAME_W+1)*DATA_PERIOD.
- Gating, highest priority after reset:
  - self_started_in=0: abort any frame and go to IDLE. data_clk_out=0, sel_out=1, data_out=0. seq is unchanged and recv/shadows are retained.
  - Otherwise, opponent_started_in=0: abort any frame and go to IDLE. data_clk_out held 1 (presence beacon), sel_out=1. Capture continues.
  - An aborted frame does not increment seq and does not restore recv.
- ch_required_in is sampled only when evaluating the trigger. Changing it mid-frame has no effect on the frame in flight.
- busy_out=1 in LOAD, SHIFT and GAP.

Test Plan:
- NUM_CH=2, CH_WIDTH=8, SEQ_WIDTH=4, DATA_PERIOD=4, both started, required=2'b11. Strobe ch0=0x5A, then ch1=0x3C a few cycles later. Required: 36 bits decoded on rising data_clk equal A5_0_3C_5A_66 (csum=00^3C^5A). sel_out low for exactly 144 cycles. frame_sent_out pulses once, then seq_out=1.
- Same config, only ch0 strobed with required=2'b11: no frame, sel_out stays 1. Then set required=2'b01: frame starts 2 cycles later.
- Strobe ch1=0xFF mid-SHIFT: the current frame still carries the old ch1. After GAP, a second frame is not sent until ch0 is also strobed. The next frame carries 0xFF with seq=1.
- Deassert opponent_started_in during bit 10: sel_out=1 and data_clk_out=1 next cycle. On reassert with recv still clear, nothing is sent. Re-strobe both channels: the frame reuses seq=0.
- self_started_in=0: data_clk_out=0, and no frame even with all recv set. 16 consecutive frames: seq wraps 15->0 and the checksum tracks seq.
- Drive rst_n_in=0 for 1 cycle mid-SHIFT: all outputs at reset values the next cycle, recv=INIT_RECV.

Source files
------------

// File: rtl/state_frame_tx.sv
// Serial frame transmitter for board-to-board game-state exchange: shadows NUM_CH
// channels and sends {HEADER, seq, channels, csum} MSB first once the required set is fresh.
module state_frame_tx #(
    parameter int                NUM_CH      = 2,
    parameter int                CH_WIDTH    = 48,
    parameter int                SEQ_WIDTH   = 4,
    parameter int                DATA_PERIOD = 100,
    parameter logic [7:0]        HEADER      = 8'hA5,
    parameter logic [NUM_CH-1:0] INIT_RECV   = '0
) (
    input  logic                         clk_pixel_in,
    input  logic                         rst_n_in,
    input  logic                         self_started_in,
    input  logic                         opponent_started_in,
    input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data_in,
    input  logic [NUM_CH-1:0]            ch_valid_in,
    input  logic [NUM_CH-1:0]            ch_required_in,
    output logic                         data_out,
    output logic                         data_clk_out,
    output logic                         sel_out,
    output logic                         busy_out,
    output logic                         frame_sent_out,
    output logic [SEQ_WIDTH-1:0]         seq_out
);
    localparam int PAY_W   = SEQ_WIDTH + NUM_CH * CH_WIDTH;
    localparam int PAD_W   = ((PAY_W + 7) / 8) * 8;
    localparam int FRAME_W = 16 + PAY_W;
    localparam int CYC_W   = $clog2(DATA_PERIOD);
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(DATA_PERIOD - 1);
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(DATA_PERIOD / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t                       state_q, state_d;
    logic [CYC_W-1:0]             cyc_q, cyc_d;
    logic [BIT_W-1:0]             bit_q, bit_d;
    logic [FRAME_W-1:0]           shreg_q, shreg_d;
    logic [SEQ_WIDTH-1:0]         seq_q, seq_d;
    logic [NUM_CH-1:0]            recv_q, recv_d;
    logic [NUM_CH*CH_WIDTH-1:0]   shadow_q, shadow_d;
    logic                         beacon_q, beacon_d;
    logic                         trigger;

    // Payload is zero-padded at the MSB to whole bytes before the byte-wise XOR.
    function automatic logic [7:0] csum_f(input logic [PAY_W-1:0] p);
        logic [PAD_W-1:0] pad;
        logic [7:0]       acc;
        pad = PAD_W'(p);
        acc = '0;
        for (int i = 0; i < PAD_W / 8; i++) begin
            acc = acc ^ pad[i*8 +: 8];
        end
        return acc;
    endfunction

    assign trigger = self_started_in && opponent_started_in && (ch_required_in != '0)
                     && ((recv_q & ch_required_in) == ch_required_in);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        seq_d    = seq_q;
        recv_d   = recv_q | ch_valid_in;
        shadow_d = shadow_q;
        beacon_d = self_started_in && !opponent_started_in;

        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid_in[i]) shadow_d[i*CH_WIDTH +: CH_WIDTH] = ch_data_in[i*CH_WIDTH +: CH_WIDTH];
        end

        if (!self_started_in || !opponent_started_in) begin
            state_d = IDLE;
            cyc_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (trigger) state_d = LOAD;
                LOAD: begin
                    shreg_d = {HEADER, seq_q, shadow_q, csum_f({seq_q, shadow_q})};
                    // A strobe landing in the LOAD cycle stays pending for the next frame.
                    recv_d  = ch_valid_in;
                    state_d = SHIFT;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
                SHIFT: begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_d   = '0;
                        shreg_d = shreg_q << 1;
                        if (bit_q == BIT_LAST) state_d = GAP;
                        else                   bit_d = bit_q + BIT_W'(1);
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
                GAP: begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_d   = '0;
                        seq_d   = seq_q + SEQ_WIDTH'(1);
                        state_d = IDLE;
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            seq_q    <= '0;
            recv_q   <= INIT_RECV;
            shadow_q <= '0;
            beacon_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            seq_q    <= seq_d;
            recv_q   <= recv_d;
            shadow_q <= shadow_d;
            beacon_q <= beacon_d;
        end
    end

    assign data_out       = (state_q == SHIFT) && shreg_q[FRAME_W-1];
    assign data_clk_out   = (state_q == SHIFT) ? (cyc_q >= CYC_HALF) : beacon_q;
    assign sel_out        = (state_q != SHIFT);
    assign busy_out       = (state_q != IDLE);
    assign frame_sent_out = (state_q == GAP) && (cyc_q == CYC_LAST);
    assign seq_out        = seq_q;
endmodule

// File: tb/tb_state_frame_tx.sv
// Randomised scoreboard bench: stimulus queues expected frames, a serial-line
// monitor decodes each sel_out window and compares it against the queue.
module tb_state_frame_tx;
    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int SW  = 4;
    localparam int DP  = 4;
    localparam int FW  = 8 + SW + NCH * CW + 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            self_st, opp_st;
    logic [NCH*CW-1:0] ch_data;
    logic [NCH-1:0]  ch_valid, ch_req;
    logic            d_out, d_clk, sel, busy, fsent;
    logic [SW-1:0]   seq;

    typedef struct {
        logic [FW-1:0] f;
        int            nb;
        int            low;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0;
    int   errs = 0;
    int   mseq = 0;

    state_frame_tx #(
        .NUM_CH(NCH), .CH_WIDTH(CW), .SEQ_WIDTH(SW), .DATA_PERIOD(DP),
        .HEADER(8'hA5), .INIT_RECV(2'b00)
    ) dut (
        .clk_pixel_in(clk), .rst_n_in(rst_n),
        .self_started_in(self_st), .opponent_started_in(opp_st),
        .ch_data_in(ch_data), .ch_valid_in(ch_valid), .ch_required_in(ch_req),
        .data_out(d_out), .data_clk_out(d_clk), .sel_out(sel),
        .busy_out(busy), .frame_sent_out(fsent), .seq_out(seq)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] frame(input int s, input logic [7:0] c1, input logic [7:0] c0);
        logic [7:0] s8;
        s8 = 8'(s % 16);
        return {8'hA5, s8[3:0], c1, c0, s8 ^ c1 ^ c0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic strobe(input logic [NCH-1:0] m, input logic [7:0] c1, input logic [7:0] c0);
        ch_data  = {c1, c0};
        ch_valid = m;
        tick(1);
        ch_valid = '0;
    endtask

    task automatic push_full(input logic [7:0] c1, input logic [7:0] c0);
        exp_q.push_back('{frame(mseq, c1, c0), FW, FW * DP});
    endtask

    task automatic push_abort(input logic [7:0] c1, input logic [7:0] c0, input int nb, input int low);
        exp_t e;
        e.f   = frame(mseq, c1, c0) >> (FW - nb);
        e.nb  = nb;
        e.low = low;
        exp_q.push_back(e);
    endtask

    task automatic wait_sent(output int n);
        n = 0;
        while (fsent !== 1'b1 && n < 400) begin tick(1); n++; end
        if (n >= 400) begin vecs++; errs++; $display("FAIL sent_timeout: no frame_sent_out within 400 cycles"); end
    endtask

    task automatic wait_sel_low();
        int n = 0;
        while (sel !== 1'b0 && n < 400) begin tick(1); n++; end
        if (n >= 400) begin vecs++; errs++; $display("FAIL sel_timeout: sel_out never went low"); end
    endtask

    task automatic finish_frame();
        int n;
        wait_sent(n);
        tick(1);
        mseq = (mseq + 1) % 16;
        chk("seq_after_frame", 64'(seq), 64'(mseq));
        chk("busy_after_frame", 64'(busy), 64'd0);
    endtask

    // Serial-line monitor: decodes bits on rising data_clk while sel is low.
    logic [FW-1:0] mbits = '0;
    int  mnb = 0, mlow = 0, since_end = 0;
    logic prev_sel = 1'b1, prev_dclk = 1'b0;

    always @(negedge clk) begin
        if (sel === 1'b0) begin
            mlow++;
            if (d_clk === 1'b1 && prev_dclk === 1'b0) begin
                mbits = {mbits[FW-2:0], d_out};
                mnb++;
            end
        end else if (prev_sel === 1'b0) begin
            if (exp_q.size() == 0) begin
                vecs++; errs++;
                $display("FAIL unexpected_frame: got %0d bits %0h, expected no frame", mnb, mbits);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_bits", 64'(mnb), 64'(e.nb));
                chk("frame_data", 64'(mbits), 64'(e.f));
                chk("sel_low_cycles", 64'(mlow), 64'(e.low));
            end
            mbits = '0; mnb = 0; mlow = 0; since_end = 0;
        end else begin
            since_end++;
        end
        if (fsent === 1'b1) chk("frame_sent_timing", 64'(since_end), 64'(DP - 1));
        prev_sel  = sel;
        prev_dclk = d_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] r0, r1;
        rst_n = 1'b0; self_st = 1'b1; opp_st = 1'b1;
        ch_data = '0; ch_valid = '0; ch_req = 2'b11;
        tick(2);
        chk("rst_data", 64'(d_out), 64'd0);
        chk("rst_dclk", 64'(d_clk), 64'd0);
        chk("rst_sel", 64'(sel), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fsent", 64'(fsent), 64'd0);
        chk("rst_seq", 64'(seq), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Basic frame and end-to-end latency
        push_full(8'h3C, 8'h5A);
        strobe(2'b01, 8'h00, 8'h5A);
        tick(3);
        strobe(2'b10, 8'h3C, 8'h00);
        wait_sent(n);
        chk("latency_frame_sent", 64'(n), 64'(1 + (FW + 1) * DP));
        tick(1);
        mseq = 1;
        chk("seq_after_first", 64'(seq), 64'd1);

        // Required mask not satisfied, then relaxed
        strobe(2'b01, 8'h00, 8'h11);
        tick(60);
        chk("no_frame_partial_sel", 64'(sel), 64'd1);
        chk("no_frame_partial_busy", 64'(busy), 64'd0);
        push_full(8'h3C, 8'h11);
        ch_req = 2'b01;
        tick(1);
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_sel", 64'(sel), 64'd1);
        tick(1);
        chk("shift_sel_t2", 64'(sel), 64'd0);
        finish_frame();

        // Capture during SHIFT does not disturb the frame in flight
        ch_req = 2'b11;
        push_full(8'h44, 8'h22);
        strobe(2'b01, 8'h00, 8'h22);
        strobe(2'b10, 8'h44, 8'h00);
        wait_sel_low();
        tick(20);
        strobe(2'b10, 8'hFF, 8'h00);
        finish_frame();
        tick(20);
        chk("wait_for_ch0_busy", 64'(busy), 64'd0);
        push_full(8'hFF, 8'h33);
        strobe(2'b01, 8'h00, 8'h33);
        finish_frame();

        // Opponent drops during bit 10
        push_abort(8'h66, 8'h55, 10, 41);
        strobe(2'b11, 8'h66, 8'h55);
        wait_sel_low();
        tick(40);
        opp_st = 1'b0;
        tick(1);
        chk("opp_abort_sel", 64'(sel), 64'd1);
        chk("opp_beacon_dclk", 64'(d_clk), 64'd1);
        chk("opp_abort_busy", 64'(busy), 64'd0);
        tick(5);
        opp_st = 1'b1;
        tick(20);
        chk("opp_no_resend", 64'(busy), 64'd0);
        chk("opp_seq_kept", 64'(seq), 64'(mseq));
        push_full(8'h88, 8'h77);
        strobe(2'b11, 8'h88, 8'h77);
        finish_frame();

        // Self not started blocks sending
        self_st = 1'b0;
        tick(1);
        chk("self_off_dclk", 64'(d_clk), 64'd0);
        strobe(2'b11, 8'hAA, 8'h99);
        tick(30);
        chk("self_off_busy", 64'(busy), 64'd0);
        chk("self_off_sel", 64'(sel), 64'd1);
        push_full(8'hAA, 8'h99);
        self_st = 1'b1;
        finish_frame();

        // 16 back-to-back random frames; seq wraps through 15 -> 0
        for (int i = 0; i < 16; i++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            push_full(r1, r0);
            strobe(2'b11, r1, r0);
            finish_frame();
        end

        // Reset mid-SHIFT
        push_abort(8'h6F, 8'h5E, 3, 14);
        strobe(2'b11, 8'h6F, 8'h5E);
        wait_sel_low();
        tick(13);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_sel", 64'(sel), 64'd1);
        chk("midrst_dclk", 64'(d_clk), 64'd0);
        chk("midrst_data", 64'(d_out), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_fsent", 64'(fsent), 64'd0);
        chk("midrst_seq", 64'(seq), 64'd0);
        rst_n = 1'b1;
        mseq = 0;
        tick(20);
        chk("post_rst_idle", 64'(busy), 64'd0);
        // Shadow of ch1 must have been cleared by reset
        push_full(8'h00, 8'h12);
        ch_req = 2'b01;
        strobe(2'b01, 8'h00, 8'h12);
        finish_frame();

        tick(10);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
